// File: rtl/timed_event_scheduler.sv
// timed_event_scheduler
//   Multi-channel timestamped event scheduler. {timestamp, payload} words from
//   the AXI-Stream write path are queued in one FIFO per channel. A shared time
//   counter runs under software control. Each channel pops its head entry when
//   the head timestamp is reached (or has already passed, which counts as late),
//   and the payload is presented on that channel's output one cycle later.
//
//   Ports
//     aclk, aresetn            clock, asynchronous active-low reset
//     in_tvalid/tready/tdata   write stream, tdata = {timestamp, payload}
//     in_tdest                 target channel; values >= NUM_CH are accepted and dropped
//     ctrl_wr, ctrl_data       control strobe: bit0 run, bit1 clear counter,
//                              bit2 flush all FIFOs, bit3 clear late flags
//     out_tvalid/out_tdata     per-channel release pulse and held payload
//     cur_time, running        time counter and run state
//     late_flag                sticky per-channel late indicator
//     fifo_count               per-channel occupancy
//
//   Build option: define SCHED_LATE_DROP_EN to discard late entries instead of
//   emitting them (late_flag is set either way).
module timed_event_scheduler #(
    parameter int  NUM_CH     = 2,
    parameter int  FIFO_DEPTH = 16,
    parameter int  TS_WIDTH   = 64,
    parameter int  DATA_WIDTH = 64,
    localparam int DEST_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           in_tvalid,
    output logic                           in_tready,
    input  logic [TS_WIDTH+DATA_WIDTH-1:0] in_tdata,
    input  logic [DEST_W-1:0]              in_tdest,
    input  logic                           ctrl_wr,
    input  logic [3:0]                     ctrl_data,
    output logic [NUM_CH-1:0]              out_tvalid,
    output logic [NUM_CH*DATA_WIDTH-1:0]   out_tdata,
    output logic [TS_WIDTH-1:0]            cur_time,
    output logic                           running,
    output logic [NUM_CH-1:0]              late_flag,
    output logic [NUM_CH*CW-1:0]           fifo_count
);

    logic [TS_WIDTH-1:0] cur_time_q, cur_time_d;
    logic                running_q, running_d;
    logic [NUM_CH-1:0]   full;
    logic                sel_full;
    logic                wr_fire, flush, clr_late;

    assign flush    = ctrl_wr & ctrl_data[2];
    assign clr_late = ctrl_wr & ctrl_data[3];

    // Back-pressure only from the addressed channel; out-of-range dests never stall.
    always_comb begin
        sel_full = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if (in_tdest == DEST_W'(c)) sel_full = full[c];
    end

    // Blocking writes during ctrl_wr keeps a flush from racing a push.
    assign in_tready = ~ctrl_wr & ~sel_full;
    assign wr_fire   = in_tvalid & in_tready;

    always_comb begin
        running_d  = running_q;
        cur_time_d = cur_time_q;
        if (ctrl_wr) running_d = ctrl_data[0];
        if (ctrl_wr && ctrl_data[1]) cur_time_d = '0;
        else if (running_q)          cur_time_d = cur_time_q + TS_WIDTH'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cur_time_q <= '0;
            running_q  <= 1'b0;
        end else begin
            cur_time_q <= cur_time_d;
            running_q  <= running_d;
        end
    end

    assign cur_time = cur_time_q;
    assign running  = running_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [TS_WIDTH+DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0]         wptr_q, rptr_q;
        logic [CW-1:0]         cnt_q;
        logic                  vld_q, late_q;
        logic [DATA_WIDTH-1:0] dat_q;
        logic [TS_WIDTH-1:0]   head_ts;
        logic [DATA_WIDTH-1:0] head_dat;
        logic                  push, eval, due, late, emit;

        assign head_ts  = mem_q[rptr_q][TS_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
        assign head_dat = mem_q[rptr_q][DATA_WIDTH-1:0];
        assign push     = wr_fire & (in_tdest == DEST_W'(c));

        // A word written this cycle is not visible at the head until next cycle,
        // since the count only updates on the clock edge.
        assign eval = running_q & (cnt_q != '0) & ~flush;
        assign due  = eval & (head_ts <= cur_time_q);
        assign late = eval & (head_ts <  cur_time_q);
`ifdef SCHED_LATE_DROP_EN
        assign emit = due & ~late;
`else
        assign emit = due;
`endif

        always_ff @(posedge aclk) begin
            if (push) mem_q[wptr_q] <= in_tdata;
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                vld_q  <= 1'b0;
                dat_q  <= '0;
                late_q <= 1'b0;
            end else begin
                if (flush) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    if (push) wptr_q <= wptr_q + AW'(1);
                    if (due)  rptr_q <= rptr_q + AW'(1);
                    cnt_q <= cnt_q + CW'(push) - CW'(due);
                end
                vld_q <= emit;
                if (emit) dat_q <= head_dat;
                // A late detection in the clearing cycle still leaves the flag set.
                late_q <= (late_q & ~clr_late) | late;
            end
        end

        assign full[c]                                = (cnt_q == CW'(FIFO_DEPTH));
        assign out_tvalid[c]                          = vld_q;
        assign out_tdata[c*DATA_WIDTH +: DATA_WIDTH]  = dat_q;
        assign late_flag[c]                           = late_q;
        assign fifo_count[c*CW +: CW]                 = cnt_q;
    end

endmodule
